dram_window_streamer: RTL and testbench

Downstream readout stage of the image-downsampling processor. Once the processor signals completion, it scans a rectangular window of data RAM holding the downsampled image row by row. It streams each byte out on a valid/ready byte interface with end-of-row and end-of-frame markers, feeding the host link or capture logic. It owns the data-RAM read address while active.

---
 rtl/dram_window_streamer.sv | 145 ++++++++++++++
 tb/tb_dram_window_streamer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_window_streamer.sv
// Scans a rectangular window of data RAM row by row and streams each pixel
// on a valid/ready byte interface tagged with end-of-row / end-of-frame markers.
module dram_window_streamer #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int BASE   = 269,
    parameter int COLS   = 129,
    parameter int ROWS   = 128,
    parameter int STRIDE = 258
) (
    input  logic              clk,
    input  logic              power_ON,
    input  logic              processor_status,
    output logic [ADDR_W-1:0] dRamAddr,
    input  logic [DATA_W-1:0] dRamOut,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int E_W   = DATA_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q;
    logic              status_q;
    logic              busy_q, done_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [ADDR_W-1:0] row_base_q, addr_q;
    logic              infl_q, infl_eol_q, infl_last_q;
    logic [1:0]        cnt_q;
    logic [E_W-1:0]    ent0_q, ent1_q;

    logic              start, pop, issue, col_end, row_end;
    logic [E_W-1:0]    in_ent;

    always_comb begin
        start   = processor_status & ~status_q;
        pop     = (cnt_q != 2'd0) & out_ready;
        col_end = (col_q == COL_W'(COLS - 1));
        row_end = (row_q == ROW_W'(ROWS - 1));
        // Only issue if the read still has a FIFO slot when it lands next cycle.
        issue   = (state_q == RUN) &&
                  (({1'b0, cnt_q} - {2'b00, pop} + {2'b00, infl_q}) < 3'd2);
        in_ent  = {infl_eol_q, infl_last_q, dRamOut};
    end

    always_ff @(posedge clk) begin
        if (power_ON) begin
            state_q  <= IDLE;
            status_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            infl_q   <= 1'b0;
        end else begin
            status_q <= processor_status;
            infl_q   <= issue;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        row_q      <= '0;
                        col_q      <= '0;
                        row_base_q <= ADDR_W'(BASE);
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q      <= row_base_q + ADDR_W'(col_q);
                        infl_eol_q  <= col_end;
                        infl_last_q <= col_end & row_end;
                        if (col_end) begin
                            col_q      <= '0;
                            row_q      <= row_q + ROW_W'(1);
                            row_base_q <= row_base_q + ADDR_W'(STRIDE);
                            if (row_end) state_q <= DRAIN;
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && ent0_q[DATA_W]) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!processor_status) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry output FIFO; ent0_q is the head and drives the outputs directly.
    always_ff @(posedge clk) begin
        if (power_ON) begin
            cnt_q  <= 2'd0;
            ent0_q <= '0;
        end else begin
            case ({infl_q, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) ent0_q <= in_ent;
                    else               ent1_q <= in_ent;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        ent0_q <= in_ent;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= in_ent;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dRamAddr  = addr_q;
    assign out_data  = ent0_q[DATA_W-1:0];
    assign out_last  = ent0_q[DATA_W];
    assign out_eol   = ent0_q[DATA_W+1];
    assign out_valid = (cnt_q != 2'd0);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dram_window_streamer.sv
// Bench for dram_window_streamer: default-size window against a raster-scan
// reference model, plus a tiny window with hand-computed beats.
module tb_dram_window_streamer;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int BASE   = 269;
    localparam int COLS   = 129;
    localparam int ROWS   = 128;
    localparam int STRIDE = 258;
    localparam int NB     = ROWS * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              power_ON, processor_status, out_ready;
    logic [ADDR_W-1:0] dRamAddr;
    logic [DATA_W-1:0] dRamOut, out_data;
    logic              out_valid, out_eol, out_last, busy, done;

    logic              s_status;
    logic              s_ready = 1'b1;
    logic [7:0]        s_addr, s_dout, s_data;
    logic              s_valid, s_eol, s_last, s_busy, s_done;

    int total = 0;
    int bad   = 0;

    int                issued, accepted;
    logic              held, exp_done, chk_en;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] hd;
    logic              he, hl;
    int                addr_log [NB];
    logic              rnd_mode = 1'b0;
    logic              stall    = 1'b0;

    function automatic logic [7:0] ramf(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
    endfunction

    // Reference: beat k is pixel (k / COLS, k % COLS) of the window.
    function automatic int m_addr(input int k);
        return BASE + (k / COLS) * STRIDE + (k % COLS);
    endfunction
    function automatic logic m_eol(input int k);
        return (k % COLS) == COLS - 1;
    endfunction
    function automatic logic m_last(input int k);
        return k == NB - 1;
    endfunction

    assign dRamOut = ramf(dRamAddr);
    assign s_dout  = s_addr;

    dram_window_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE),
        .COLS(COLS), .ROWS(ROWS), .STRIDE(STRIDE)
    ) dut (
        .clk(clk), .power_ON(power_ON), .processor_status(processor_status),
        .dRamAddr(dRamAddr), .dRamOut(dRamOut), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol),
        .out_last(out_last), .busy(busy), .done(done)
    );

    dram_window_streamer #(
        .ADDR_W(8), .DATA_W(8), .BASE(1), .COLS(3), .ROWS(2), .STRIDE(5)
    ) dut_s (
        .clk(clk), .power_ON(power_ON), .processor_status(s_status),
        .dRamAddr(s_addr), .dRamOut(s_dout), .out_data(s_data),
        .out_valid(s_valid), .out_ready(s_ready), .out_eol(s_eol),
        .out_last(s_last), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        issued    = 0;
        accepted  = 0;
        held      = 1'b0;
        exp_done  = 1'b0;
        last_addr = dRamAddr;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout actual=0 required=1 after %0d cycles", cyc);
        end
    endtask

    task automatic wait_accept(input int n, input int budget);
        int cyc = 0;
        while (accepted < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (accepted < n) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=%0d required=%0d", accepted, n);
        end
    endtask

    // Sink ready: random 30% duty for the early part of a random-mode scan.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (stall)                           out_ready = 1'b0;
            else if (rnd_mode && accepted < 3000) out_ready = ($urandom_range(0, 99) < 30);
            else                                 out_ready = 1'b1;
        end
    end

    // Per-cycle compare of the streamed window against the reference model.
    initial begin
        chk_en = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (dRamAddr != last_addr) begin
                    if (issued < NB) addr_log[issued] = 32'(dRamAddr);
                    chk("rd_addr", 32'(dRamAddr), 32'(m_addr(issued)));
                    issued++;
                    last_addr = dRamAddr;
                end
                chk("outstanding_le2", 32'((issued - accepted) <= 2), 32'd1);
                if (exp_done) begin
                    chk("done_after_last", 32'({done, busy}), 32'b10);
                    exp_done = 1'b0;
                end
                if (held)
                    chk("stall_stable", 32'({out_valid, out_eol, out_last, out_data}),
                        32'({1'b1, he, hl, hd}));
                if (out_valid) begin
                    if (out_ready) begin
                        chk("beat", 32'({out_eol, out_last, out_data}),
                            32'({m_eol(accepted), m_last(accepted), ramf(ADDR_W'(m_addr(accepted)))}));
                        if (m_last(accepted)) exp_done = 1'b1;
                        accepted++;
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                        hd = out_data; he = out_eol; hl = out_last;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        int k, n, cyc, nbad, iss0;
        logic [ADDR_W-1:0] a5;
        logic [9:0] s_got [6];
        logic [9:0] s_exp [6];
        s_exp = '{10'h001, 10'h002, 10'h203, 10'h006, 10'h007, 10'h308};

        power_ON = 1'b1; processor_status = 1'b0; s_status = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_main", 32'({dRamAddr, out_data, out_valid, out_eol, out_last, busy, done}), 32'd0);
        chk("reset_small", 32'({s_addr, s_data, s_valid, s_eol, s_last, s_busy, s_done}), 32'd0);
        power_ON = 1'b0;

        // Tiny window: RAM[a] = a
        s_status = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            s_status = 1'b0;
            k++;
        end while (!s_valid && k < 10);
        chk("small_first_valid_edges", k, 3);
        n = 0;
        for (int i = 0; i < 12 && n < 6; i++) begin
            if (s_valid) begin
                s_got[n] = {s_eol, s_last, s_data};
                n++;
            end
            @(posedge clk); #1;
        end
        chk("small_beat_count", n, 6);
        for (int i = 0; i < 6; i++) chk("small_beat", 32'(s_got[i]), 32'(s_exp[i]));
        chk("small_done", 32'({s_done, s_busy}), 32'b10);

        // Full window, ready held high, status held high
        clear_model();
        chk_en = 1'b1;
        processor_status = 1'b1;
        wait_done(20000, cyc);
        chk("scan1_cycles", cyc, NB + 3);
        chk("scan1_beats", accepted, NB);
        chk("scan1_reads", issued, NB);
        chk("first_addr", addr_log[0], 269);
        chk("row0_eol_addr", addr_log[COLS-1], 397);
        chk("row1_addr", addr_log[COLS], 527);
        chk("last_addr", addr_log[NB-1], 33163);

        nbad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (!done || busy || out_valid || dRamAddr != ADDR_W'(33163)) nbad++;
        end
        chk("hold_no_restart", nbad, 0);
        processor_status = 1'b0;
        @(posedge clk); #1;
        chk("done_clears", 32'({done, busy}), 32'd0);

        // Second scan, aborted by power_ON after 500 beats
        clear_model();
        processor_status = 1'b1;
        @(posedge clk); #1;
        processor_status = 1'b0;
        wait_accept(500, 2000);
        chk_en = 1'b0;
        power_ON = 1'b1;
        @(posedge clk); #1;
        chk("abort_reset", 32'({dRamAddr, out_data, out_valid, out_eol, out_last, busy, done}), 32'd0);
        power_ON = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_stays_idle", 32'({out_valid, busy, done}), 32'd0);

        // Restart with random ready and a 20-cycle stall mid-row
        clear_model();
        chk_en = 1'b1;
        rnd_mode = 1'b1;
        processor_status = 1'b1;
        @(posedge clk); #1;
        processor_status = 1'b0;
        wait_accept(5060, 30000);
        stall = 1'b1;
        iss0 = issued;
        repeat (5) begin
            @(posedge clk); #1;
        end
        a5 = dRamAddr;
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk("stall_reads_le2", 32'((issued - iss0) <= 2), 32'd1);
        chk("stall_addr_hold", 32'(dRamAddr), 32'(a5));
        stall = 1'b0;
        wait_done(40000, cyc);
        chk("scan3_beats", accepted, NB);
        chk("scan3_reads", issued, NB);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
